// File: rtl/ysyx_25040129_icache_if.sv
// IFU fetch channel and AXI-style refill read channel of the instruction cache.
// master = initiator side, slave = responder side.
interface ysyx_25040129_icache_ifu_if;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_resp_valid;
  logic        ifu_resp_ready;
  logic [31:0] ifu_inst;
  logic        ifu_err;

  modport master (
    output ifu_req_valid, ifu_addr, ifu_resp_ready,
    input  ifu_req_ready, ifu_resp_valid, ifu_inst, ifu_err
  );
  modport slave (
    input  ifu_req_valid, ifu_addr, ifu_resp_ready,
    output ifu_req_ready, ifu_resp_valid, ifu_inst, ifu_err
  );
endinterface

interface ysyx_25040129_icache_axi_if;
  logic [31:0] icache_araddr;
  logic        icache_arvalid;
  logic        icache_arready;
  logic [7:0]  icache_arlen;
  logic [1:0]  icache_arburst;
  logic [31:0] icache_rdata;
  logic [1:0]  icache_rresp;
  logic        icache_rvalid;
  logic        icache_rready;
  logic        icache_rlast;

  modport master (
    output icache_araddr, icache_arvalid, icache_arlen, icache_arburst, icache_rready,
    input  icache_arready, icache_rdata, icache_rresp, icache_rvalid, icache_rlast
  );
  modport slave (
    input  icache_araddr, icache_arvalid, icache_arlen, icache_arburst, icache_rready,
    output icache_arready, icache_rdata, icache_rresp, icache_rvalid, icache_rlast
  );
endinterface

// File: rtl/ysyx_25040129_icache.sv
// Direct-mapped read-only instruction cache with whole-line INCR burst refill
// and whole-cache invalidate for fence.i.
module ysyx_25040129_icache #(
  parameter int unsigned NSETS      = 16,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         fence_i,
  ysyx_25040129_icache_ifu_if.slave    ifu,
  ysyx_25040129_icache_axi_if.master   bus
);

  localparam int unsigned INDEX_W = $clog2(NSETS);
  localparam int unsigned OFF_W   = $clog2(LINE_WORDS * 4);
  localparam int unsigned WOFF_W  = OFF_W - 2;
  localparam int unsigned TAG_W   = 32 - INDEX_W - OFF_W;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOOKUP  = 3'd1;
  localparam logic [2:0] S_MISS_AR = 3'd2;
  localparam logic [2:0] S_MISS_R  = 3'd3;
  localparam logic [2:0] S_RESP    = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [31:2]       addr_q, addr_d;
  logic              fence_pend_q, fence_pend_d;
  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       inst_q, inst_d;
  logic              err_q, err_d;
  logic              arvalid_q, arvalid_d;
  logic [31:0]       araddr_q, araddr_d;
  logic              rready_q, rready_d;
  logic [WOFF_W-1:0] cnt_q, cnt_d;
  logic              fill_err_q, fill_err_d;

  logic [NSETS-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [NSETS];
  logic [31:0]       data_q [NSETS][LINE_WORDS];

  logic [INDEX_W-1:0] idx_in, idx_q;
  logic [TAG_W-1:0]   tag_in, tag_lat;
  logic [WOFF_W-1:0]  woff_in, woff_q;
  logic               req_ready_c, accept_c, hit_c;
  logic               beat_c, fill_last_c, beat_err_c, clear_all_c;
  logic               unused_addr_lsb;

  assign idx_in  = ifu.ifu_addr[OFF_W +: INDEX_W];
  assign tag_in  = ifu.ifu_addr[31 -: TAG_W];
  assign woff_in = ifu.ifu_addr[2 +: WOFF_W];
  assign idx_q   = addr_q[OFF_W +: INDEX_W];
  assign tag_lat = addr_q[31 -: TAG_W];
  assign woff_q  = addr_q[2 +: WOFF_W];
  assign unused_addr_lsb = ^ifu.ifu_addr[1:0];

  // A fence seen this cycle or still pending blocks acceptance until it is applied.
  assign req_ready_c = (state_q == S_IDLE) && !fence_pend_q && !fence_i;
  assign accept_c    = ifu.ifu_req_valid && req_ready_c;
  assign hit_c       = valid_q[idx_in] && (tag_q[idx_in] == tag_in);
  assign beat_c      = rready_q && bus.icache_rvalid;
  assign fill_last_c = beat_c && bus.icache_rlast;
  assign beat_err_c  = fill_err_q || (bus.icache_rresp != 2'b00);
  assign clear_all_c = (state_q == S_IDLE) && (fence_pend_q || fence_i);

  assign ifu.ifu_req_ready  = req_ready_c;
  assign ifu.ifu_resp_valid = resp_valid_q;
  assign ifu.ifu_inst       = inst_q;
  assign ifu.ifu_err        = err_q;

  assign bus.icache_araddr  = araddr_q;
  assign bus.icache_arvalid = arvalid_q;
  assign bus.icache_arlen   = 8'(LINE_WORDS - 1);
  assign bus.icache_arburst = 2'b01;
  assign bus.icache_rready  = rready_q;

  // Tag compare happens at accept so the hit response leaves a register one cycle later.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    fence_pend_d = fence_pend_q;
    resp_valid_d = resp_valid_q;
    inst_d       = inst_q;
    err_d        = err_q;
    arvalid_d    = arvalid_q;
    araddr_d     = araddr_q;
    rready_d     = rready_q;
    cnt_d        = cnt_q;
    fill_err_d   = fill_err_q;

    if (fence_i && (state_q != S_IDLE)) begin
      fence_pend_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (clear_all_c) begin
          fence_pend_d = 1'b0;
        end
        if (accept_c) begin
          addr_d  = ifu.ifu_addr[31:2];
          state_d = S_LOOKUP;
          if (hit_c) begin
            resp_valid_d = 1'b1;
            inst_d       = data_q[idx_in][woff_in];
            err_d        = 1'b0;
          end
        end
      end
      S_LOOKUP: begin
        if (resp_valid_q) begin
          if (ifu.ifu_resp_ready) begin
            resp_valid_d = 1'b0;
            state_d      = S_IDLE;
          end
        end else begin
          arvalid_d = 1'b1;
          araddr_d  = {addr_q[31:OFF_W], OFF_W'(0)};
          state_d   = S_MISS_AR;
        end
      end
      S_MISS_AR: begin
        if (bus.icache_arready) begin
          arvalid_d  = 1'b0;
          rready_d   = 1'b1;
          cnt_d      = '0;
          fill_err_d = 1'b0;
          state_d    = S_MISS_R;
        end
      end
      S_MISS_R: begin
        if (bus.icache_rvalid) begin
          cnt_d      = WOFF_W'(cnt_q + 1'b1);
          fill_err_d = beat_err_c;
          if (cnt_q == woff_q) begin
            inst_d = bus.icache_rdata;
          end
          if (bus.icache_rlast) begin
            rready_d     = 1'b0;
            resp_valid_d = 1'b1;
            err_d        = beat_err_c;
            state_d      = S_RESP;
          end
        end
      end
      S_RESP: begin
        if (ifu.ifu_resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      fence_pend_q <= 1'b0;
      resp_valid_q <= 1'b0;
      inst_q       <= '0;
      err_q        <= 1'b0;
      arvalid_q    <= 1'b0;
      araddr_q     <= '0;
      rready_q     <= 1'b0;
      cnt_q        <= '0;
      fill_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      fence_pend_q <= fence_pend_d;
      resp_valid_q <= resp_valid_d;
      inst_q       <= inst_d;
      err_q        <= err_d;
      arvalid_q    <= arvalid_d;
      araddr_q     <= araddr_d;
      rready_q     <= rready_d;
      cnt_q        <= cnt_d;
      fill_err_q   <= fill_err_d;
    end
  end

  // Valid bits: fence clears only in IDLE, refill updates only in MISS_R, so they never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (clear_all_c) begin
      valid_q <= '0;
    end else if (fill_last_c) begin
      valid_q[idx_q] <= !beat_err_c;
    end
  end

  always_ff @(posedge clk) begin
    if (beat_c) begin
      data_q[idx_q][cnt_q] <= bus.icache_rdata;
    end
    if (fill_last_c) begin
      tag_q[idx_q] <= tag_lat;
    end
  end

endmodule

// File: tb/tb_ysyx_25040129_icache.sv
// Randomized scoreboard bench for the instruction cache: driver, AXI responder
// and response monitor run as separate processes against a line-level model.
module tb_ysyx_25040129_icache;
  localparam int unsigned NSETS      = 16;
  localparam int unsigned LINE_WORDS = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic fence_i = 1'b0;
  always #5 clk = ~clk;

  ysyx_25040129_icache_ifu_if ifu_b ();
  ysyx_25040129_icache_axi_if axi_b ();

  ysyx_25040129_icache #(.NSETS(NSETS), .LINE_WORDS(LINE_WORDS)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .fence_i (fence_i),
    .ifu     (ifu_b),
    .bus     (axi_b)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] inst;
    logic        err;
    logic        miss;
    int          acc_cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          inj_q[$];
  logic        mvalid [NSETS];
  logic [27:0] mline  [NSETS];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ar_cnt = 0;
  int ar_hold = 0;
  int resp_hold = 0;
  int rlast_cyc = 0;
  logic [31:0] last_ar_addr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w[31:4] == 28'h8000001) return 32'hA0 + 32'(w[3:2]);
    return (w * 32'h9E37_79B1) ^ 32'h0BAD_CAFE;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_fence();
    for (int i = 0; i < int'(NSETS); i++) mvalid[i] = 1'b0;
  endtask

  task automatic fence_pulse();
    @(negedge clk);
    fence_i = 1'b1;
    model_fence();
    @(negedge clk);
    fence_i = 1'b0;
  endtask

  // Drive one fetch until accepted; the expectation is pushed at acceptance.
  task automatic fetch(input logic [31:0] a, input int inj, input bit with_fence);
    int          t;
    bit          acc;
    int unsigned set;
    exp_t        e;
    t = 0;
    acc = 1'b0;
    @(negedge clk);
    ifu_b.ifu_req_valid = 1'b1;
    ifu_b.ifu_addr = a;
    if (with_fence) begin
      fence_i = 1'b1;
      model_fence();
      #1;
      check("fence_blocks_accept", 32'(ifu_b.ifu_req_ready), 32'd0);
      @(negedge clk);
      fence_i = 1'b0;
    end
    while (!acc && t < 400) begin
      #1;
      if (ifu_b.ifu_req_ready) begin
        acc = 1'b1;
        set = (a >> 4) % NSETS;
        e.addr = a;
        e.inst = mem_word(a);
        e.miss = !(mvalid[set] && mline[set] == a[31:4]);
        e.err = e.miss && (inj >= 0);
        e.acc_cyc = cyc + 1;
        exp_q.push_back(e);
        if (e.miss) begin
          inj_q.push_back(inj);
          mvalid[set] = (inj < 0);
          mline[set] = a[31:4];
        end
      end else begin
        t++;
        @(negedge clk);
      end
    end
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
    @(negedge clk);
    ifu_b.ifu_req_valid = 1'b0;
  endtask

  // AXI read responder with random arready/rvalid gaps and optional error beat.
  initial begin : slave
    logic [31:0] base;
    logic [31:0] p_addr;
    bit          p_wait;
    bit          got;
    int          inj;
    p_wait = 1'b0;
    p_addr = '0;
    axi_b.icache_arready = 1'b0;
    axi_b.icache_rvalid = 1'b0;
    axi_b.icache_rdata = '0;
    axi_b.icache_rresp = 2'b00;
    axi_b.icache_rlast = 1'b0;
    wait (rst_n);
    forever begin
      @(negedge clk);
      axi_b.icache_rvalid = 1'b0;
      axi_b.icache_rlast = 1'b0;
      axi_b.icache_arready = (ar_hold > 0) ? 1'b0 : 1'($urandom_range(0, 1));
      #1;
      if (axi_b.icache_arvalid) begin
        if (p_wait) check("araddr_stable", axi_b.icache_araddr, p_addr);
        if (ar_hold > 0) ar_hold--;
      end
      if (axi_b.icache_arvalid && axi_b.icache_arready) begin
        p_wait = 1'b0;
        base = axi_b.icache_araddr;
        ar_cnt++;
        last_ar_addr = base;
        check("arlen", 32'(axi_b.icache_arlen), 32'(LINE_WORDS - 1));
        check("arburst", 32'(axi_b.icache_arburst), 32'd1);
        inj = (inj_q.size() > 0) ? inj_q.pop_front() : -1;
        @(negedge clk);
        axi_b.icache_arready = 1'b0;
        for (int i = 0; i < int'(LINE_WORDS); i++) begin
          got = 1'b0;
          while (!got) begin
            axi_b.icache_rvalid = ($urandom_range(0, 3) != 0);
            axi_b.icache_rdata = mem_word(base + 32'(4 * i));
            axi_b.icache_rresp = (i == inj) ? 2'b10 : 2'b00;
            axi_b.icache_rlast = (i == int'(LINE_WORDS) - 1);
            #1;
            if (axi_b.icache_rvalid && axi_b.icache_rready) begin
              got = 1'b1;
              if (axi_b.icache_rlast) rlast_cyc = cyc + 1;
            end
            @(negedge clk);
          end
        end
        axi_b.icache_rvalid = 1'b0;
        axi_b.icache_rlast = 1'b0;
      end else begin
        p_wait = axi_b.icache_arvalid;
        p_addr = axi_b.icache_araddr;
      end
    end
  end

  // Response monitor: pops the scoreboard whenever a response is consumed.
  initial begin : monitor
    exp_t        e;
    bit          held;
    logic [31:0] p_inst;
    logic        p_err;
    int          ar_base;
    held = 1'b0;
    p_inst = '0;
    p_err = 1'b0;
    ar_base = 0;
    ifu_b.ifu_resp_ready = 1'b0;
    wait (rst_n);
    forever begin
      @(negedge clk);
      ifu_b.ifu_resp_ready = (resp_hold > 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
      #2;
      if (ifu_b.ifu_resp_valid) begin
        check("req_ready_while_resp", 32'(ifu_b.ifu_req_ready), 32'd0);
        if (held) begin
          check("inst_stable", ifu_b.ifu_inst, p_inst);
          check("err_stable", 32'(ifu_b.ifu_err), 32'(p_err));
        end else if (exp_q.size() == 0) begin
          check("unexpected_resp", 32'd1, 32'd0);
        end else begin
          e = exp_q[0];
          check("resp_latency", 32'(cyc), 32'(e.miss ? rlast_cyc : e.acc_cyc));
          check("refill_count", 32'(ar_cnt - ar_base), 32'(e.miss));
          if (e.miss) check("araddr", last_ar_addr, {e.addr[31:4], 4'h0});
          ar_base = ar_cnt;
        end
        if (resp_hold > 0) resp_hold--;
        if (ifu_b.ifu_resp_ready) begin
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("inst", ifu_b.ifu_inst, e.inst);
            check("err", 32'(ifu_b.ifu_err), 32'(e.err));
          end
          held = 1'b0;
        end else begin
          held = 1'b1;
          p_inst = ifu_b.ifu_inst;
          p_err = ifu_b.ifu_err;
        end
      end else begin
        if (held) check("resp_dropped", 32'd0, 32'd1);
        held = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    logic [31:0] a;
    int          inj;
    bit          wf;
    int          t;
    ifu_b.ifu_req_valid = 1'b0;
    ifu_b.ifu_addr = '0;
    model_fence();
    for (int i = 0; i < int'(NSETS); i++) mline[i] = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_req_ready", 32'(ifu_b.ifu_req_ready), 32'd1);
    check("rst_resp_valid", 32'(ifu_b.ifu_resp_valid), 32'd0);
    check("rst_inst", ifu_b.ifu_inst, 32'd0);
    check("rst_err", 32'(ifu_b.ifu_err), 32'd0);
    check("rst_arvalid", 32'(axi_b.icache_arvalid), 32'd0);
    check("rst_rready", 32'(axi_b.icache_rready), 32'd0);
    check("rst_araddr", axi_b.icache_araddr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Cold miss, hit in the same line, conflicting line, re-miss.
    fetch(32'h8000_0014, -1, 1'b0);
    fetch(32'h8000_001C, -1, 1'b0);
    fetch(32'h8000_0110, -1, 1'b0);
    fetch(32'h8000_0010, -1, 1'b0);
    // Error beat leaves the line invalid.
    fetch(32'h8000_0020, 2, 1'b0);
    fetch(32'h8000_0020, -1, 1'b0);
    // Address and response backpressure.
    ar_hold = 5;
    resp_hold = 3;
    fetch(32'h8000_0234, -1, 1'b0);
    // Fence while the refill is streaming.
    fetch(32'h8000_0040, -1, 1'b0);
    t = 0;
    while (t < 300) begin
      @(negedge clk);
      #3;
      if (axi_b.icache_rready) break;
      t++;
    end
    if (t >= 300) check("wait_rready_timeout", 32'd0, 32'd1);
    fence_i = 1'b1;
    model_fence();
    @(negedge clk);
    fence_i = 1'b0;
    fetch(32'h8000_0040, -1, 1'b0);
    // Fence in IDLE together with a request.
    fetch(32'h8000_0044, -1, 1'b0);
    fetch(32'h8000_0048, -1, 1'b1);

    for (int n = 0; n < 160; n++) begin
      a = 32'h8000_0000 + (32'($urandom_range(0, 2)) << 12) + (32'($urandom_range(0, 5)) << 4)
        + (32'($urandom_range(0, LINE_WORDS - 1)) << 2) + 32'($urandom_range(0, 3));
      inj = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, LINE_WORDS - 1)) : -1;
      wf = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 15) == 0) ar_hold = int'($urandom_range(1, 4));
      if ($urandom_range(0, 15) == 0) resp_hold = int'($urandom_range(1, 4));
      fetch(a, inj, wf);
      if ($urandom_range(0, 11) == 0) begin
        repeat ($urandom_range(0, 6)) @(negedge clk);
        fence_pulse();
      end
    end

    t = 0;
    while (exp_q.size() > 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
